// File: rtl/game_pkg.sv
// Shared types and default timing for the turn arbiter and its second timer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AIM,
        ST_THROW,
        ST_FLIGHT,
        ST_SETTLE,
        ST_OVER
    } turn_state_t;

    typedef enum logic {
        DOG = 1'b0,
        CAT = 1'b1
    } player_t;

    localparam int DEF_CLK_HZ       = 65_000_000;
    localparam int DEF_TURN_SECONDS = 10;
    localparam int DEF_FLIGHT_MAX   = 195_000_000;
    localparam int DEF_SETTLE_CYC   = 32_500_000;
    localparam int DEF_DOG_FIRST    = 1;

    // Width of a counter whose count spans 0..max_val-1, never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/turn_sec_timer.sv
// One-second tick divider plus aim-seconds down-counter. The tick is frozen
// while hold is high, and expire flags a tick wrap with the seconds already at 0.
module turn_sec_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int TURN_SECONDS = DEF_TURN_SECONDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       run,
    input  logic       hold,
    output logic [3:0] secs_left,
    output logic       expire
);

    localparam int            TW        = cnt_width(CLK_HZ);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);

    logic [TW-1:0] tick_reg, tick_next;
    logic [3:0]    secs_reg, secs_next;
    logic          wrap;

    assign wrap      = run && !hold && (tick_reg == TICK_LAST);
    assign expire    = wrap && (secs_reg == 4'd0);
    assign secs_left = secs_reg;

    // Next tick/seconds: load wins, otherwise count while running and not held.
    always_comb begin
        tick_next = tick_reg;
        secs_next = secs_reg;
        if (load) begin
            tick_next = '0;
            secs_next = 4'(TURN_SECONDS);
        end else if (run && !hold) begin
            if (wrap) begin
                tick_next = '0;
                if (secs_reg != 4'd0) begin
                    secs_next = secs_reg - 4'd1;
                end
            end else begin
                tick_next = tick_reg + TW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_reg <= '0;
            secs_reg <= 4'd0;
        end else begin
            tick_reg <= tick_next;
            secs_reg <= secs_next;
        end
    end

endmodule

// File: rtl/turn_manager.sv
// Global turn arbiter: grants the dog/cat local FSMs in turn, follows their
// draw/throw handshake, waits for the projectile to land (or a flight timeout),
// inserts a settle gap and hands the turn to the opponent.
module turn_manager
    import game_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int TURN_SECONDS = DEF_TURN_SECONDS,
    parameter int FLIGHT_MAX   = DEF_FLIGHT_MAX,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int DOG_FIRST    = DEF_DOG_FIRST
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_game,
    input  logic       game_over,
    input  logic       dog_draw,
    input  logic       dog_throw,
    input  logic       cat_draw,
    input  logic       cat_throw,
    input  logic       proj_landed,
    output logic       dog_turn,
    output logic       cat_turn,
    output logic       flight_active,
    output logic [3:0] secs_left,
    output logic [7:0] turn_no,
    output logic       timeout_p
);

    localparam int            FW          = cnt_width(FLIGHT_MAX);
    localparam logic [FW-1:0] FLIGHT_LAST = FW'(FLIGHT_MAX - 1);
    localparam int            SW          = cnt_width(SETTLE_CYC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam player_t       OPENER      = (DOG_FIRST != 0) ? DOG : CAT;

    turn_state_t   state_reg, state_next;
    player_t       player_reg, player_next;
    logic [FW-1:0] flight_reg, flight_next;
    logic [SW-1:0] settle_reg, settle_next;
    logic [7:0]    turn_no_reg, turn_no_next;
    logic          dog_prev_reg, cat_prev_reg;
    logic          dog_turn_reg, cat_turn_reg, flight_reg_out, timeout_reg;
    logic          timeout_next;

    logic act_draw, act_throw, act_prev, throw_rise, throw_fall;
    logic tmr_load, tmr_run, tmr_expire;

    // Only the side holding the turn is listened to.
    assign act_draw   = (player_reg == CAT) ? cat_draw     : dog_draw;
    assign act_throw  = (player_reg == CAT) ? cat_throw    : dog_throw;
    assign act_prev   = (player_reg == CAT) ? cat_prev_reg : dog_prev_reg;
    assign throw_rise = act_throw && !act_prev;
    assign throw_fall = !act_throw && act_prev;

    turn_sec_timer #(
        .CLK_HZ       (CLK_HZ),
        .TURN_SECONDS (TURN_SECONDS)
    ) u_sec_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .run       (tmr_run),
        .hold      (act_draw),
        .secs_left (secs_left),
        .expire    (tmr_expire)
    );

    // Next-state logic; game_over overrides everything and freezes all counters.
    always_comb begin
        state_next   = state_reg;
        player_next  = player_reg;
        flight_next  = flight_reg;
        settle_next  = settle_reg;
        turn_no_next = turn_no_reg;
        timeout_next = 1'b0;
        tmr_load     = 1'b0;
        tmr_run      = 1'b0;
        if (game_over) begin
            state_next = ST_OVER;
        end else begin
            case (state_reg)
                ST_IDLE, ST_OVER: begin
                    if (start_game) begin
                        state_next   = ST_AIM;
                        player_next  = OPENER;
                        turn_no_next = 8'd0;
                        tmr_load     = 1'b1;
                    end
                end
                ST_AIM: begin
                    tmr_run = 1'b1;
                    if (throw_rise) begin
                        state_next = ST_THROW;
                    end else if (tmr_expire) begin
                        state_next   = ST_SETTLE;
                        settle_next  = '0;
                        timeout_next = 1'b1;
                    end
                end
                ST_THROW: begin
                    if (throw_fall) begin
                        state_next  = ST_FLIGHT;
                        flight_next = '0;
                    end
                end
                ST_FLIGHT: begin
                    if (proj_landed || (flight_reg == FLIGHT_LAST)) begin
                        state_next  = ST_SETTLE;
                        settle_next = '0;
                    end else begin
                        flight_next = flight_reg + FW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        state_next   = ST_AIM;
                        player_next  = player_t'(~player_reg);
                        turn_no_next = turn_no_reg + 8'd1;
                        tmr_load     = 1'b1;
                    end else begin
                        settle_next = settle_reg + SW'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State, counters, throw edge history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            player_reg     <= DOG;
            flight_reg     <= '0;
            settle_reg     <= '0;
            turn_no_reg    <= 8'd0;
            dog_prev_reg   <= 1'b0;
            cat_prev_reg   <= 1'b0;
            dog_turn_reg   <= 1'b0;
            cat_turn_reg   <= 1'b0;
            flight_reg_out <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            player_reg     <= player_next;
            flight_reg     <= flight_next;
            settle_reg     <= settle_next;
            turn_no_reg    <= turn_no_next;
            dog_prev_reg   <= dog_throw;
            cat_prev_reg   <= cat_throw;
            dog_turn_reg   <= ((state_next == ST_AIM) || (state_next == ST_THROW))
                              && (player_next == DOG);
            cat_turn_reg   <= ((state_next == ST_AIM) || (state_next == ST_THROW))
                              && (player_next == CAT);
            flight_reg_out <= (state_next == ST_FLIGHT);
            timeout_reg    <= timeout_next;
        end
    end

    assign dog_turn      = dog_turn_reg;
    assign cat_turn      = cat_turn_reg;
    assign flight_active = flight_reg_out;
    assign turn_no       = turn_no_reg;
    assign timeout_p     = timeout_reg;

endmodule

// File: tb/tb_turn_manager.sv
// Directed bench for turn_manager with short timing constants.
module tb_turn_manager;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_game = 1'b0;
    logic       game_over = 1'b0;
    logic       dog_draw = 1'b0;
    logic       dog_throw = 1'b0;
    logic       cat_draw = 1'b0;
    logic       cat_throw = 1'b0;
    logic       proj_landed = 1'b0;
    logic       dog_turn, cat_turn, flight_active, timeout_p;
    logic [3:0] secs_left;
    logic [7:0] turn_no;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    turn_manager #(
        .CLK_HZ       (10),
        .TURN_SECONDS (3),
        .FLIGHT_MAX   (20),
        .SETTLE_CYC   (4),
        .DOG_FIRST    (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_game    (start_game),
        .game_over     (game_over),
        .dog_draw      (dog_draw),
        .dog_throw     (dog_throw),
        .cat_draw      (cat_draw),
        .cat_throw     (cat_throw),
        .proj_landed   (proj_landed),
        .dog_turn      (dog_turn),
        .cat_turn      (cat_turn),
        .flight_active (flight_active),
        .secs_left     (secs_left),
        .turn_no       (turn_no),
        .timeout_p     (timeout_p)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare the four 1-bit outputs in one go.
    task automatic chk_bits(input string tag, input logic e_dog, input logic e_cat,
                            input logic e_fl, input logic e_to);
        chk({tag, ".dog_turn"},      8'(dog_turn),      8'(e_dog));
        chk({tag, ".cat_turn"},      8'(cat_turn),      8'(e_cat));
        chk({tag, ".flight_active"}, 8'(flight_active), 8'(e_fl));
        chk({tag, ".timeout_p"},     8'(timeout_p),     8'(e_to));
    endtask

    initial begin
        // Reset state
        tick(2);
        chk_bits("reset", 0, 0, 0, 0);
        chk("reset.secs", 8'(secs_left), 8'd0);
        chk("reset.turn_no", turn_no, 8'd0);
        rst_n = 1'b1;
        tick(2);
        chk_bits("idle", 0, 0, 0, 0);

        // Full dog turn: draw, throw, land, settle, cat gets the turn
        start_game = 1'b1;
        tick(1);
        start_game = 1'b0;
        chk_bits("start", 1, 0, 0, 0);
        chk("start.secs", 8'(secs_left), 8'd3);
        chk("start.turn_no", turn_no, 8'd0);
        dog_draw = 1'b1;
        tick(5);
        dog_draw = 1'b0;
        chk("draw.secs_held", 8'(secs_left), 8'd3);
        dog_throw = 1'b1;
        tick(10);
        chk_bits("throw", 1, 0, 0, 0);
        dog_throw = 1'b0;
        tick(1);
        chk_bits("throw_fall", 0, 0, 1, 0);
        tick(3);
        chk_bits("flight", 0, 0, 1, 0);
        proj_landed = 1'b1;
        tick(1);
        proj_landed = 1'b0;
        chk_bits("landed", 0, 0, 0, 0);
        tick(3);
        chk_bits("settle3", 0, 0, 0, 0);
        tick(1);
        chk_bits("cat_aim", 0, 1, 0, 0);
        chk("cat_aim.turn_no", turn_no, 8'd1);
        chk("cat_aim.secs", 8'(secs_left), 8'd3);

        // Cat does nothing: timeout. Dog draw (inactive side) must not hold the timer.
        dog_draw = 1'b1;
        tick(9);
        chk("to.secs_a", 8'(secs_left), 8'd3);
        tick(1);
        chk("to.secs_b", 8'(secs_left), 8'd2);
        tick(10);
        chk("to.secs_c", 8'(secs_left), 8'd1);
        tick(10);
        chk("to.secs_d", 8'(secs_left), 8'd0);
        tick(9);
        chk_bits("to.pre", 0, 1, 0, 0);
        tick(1);
        chk_bits("to.pulse", 0, 0, 0, 1);
        tick(1);
        chk_bits("to.after", 0, 0, 0, 0);
        dog_draw = 1'b0;
        tick(2);
        chk_bits("to.settle", 0, 0, 0, 0);
        tick(1);
        chk_bits("dog_aim2", 1, 0, 0, 0);
        chk("dog_aim2.turn_no", turn_no, 8'd2);
        chk("dog_aim2.secs", 8'(secs_left), 8'd3);

        // Dog holds draw across the 0-second boundary: no forfeit; landed ignored here
        tick(30);
        chk("hold.secs0", 8'(secs_left), 8'd0);
        tick(9);
        dog_draw = 1'b1;
        proj_landed = 1'b1;
        tick(1);
        proj_landed = 1'b0;
        tick(4);
        chk_bits("hold.noto", 1, 0, 0, 0);
        dog_throw = 1'b1;
        tick(1);
        dog_draw = 1'b0;
        tick(2);
        chk_bits("hold.throw", 1, 0, 0, 0);

        // Throw ends, nothing lands: flight times out after 20 cycles
        dog_throw = 1'b0;
        tick(1);
        chk_bits("fto.enter", 0, 0, 1, 0);
        tick(19);
        chk_bits("fto.last", 0, 0, 1, 0);
        tick(1);
        chk_bits("fto.settle", 0, 0, 0, 0);
        tick(4);
        chk_bits("cat_aim3", 0, 1, 0, 0);
        chk("cat_aim3.turn_no", turn_no, 8'd3);

        // game_over during THROW with landed and throw fall in the same cycle
        cat_throw = 1'b1;
        tick(1);
        chk_bits("cat_throw", 0, 1, 0, 0);
        game_over = 1'b1;
        proj_landed = 1'b1;
        cat_throw = 1'b0;
        tick(1);
        proj_landed = 1'b0;
        chk_bits("over", 0, 0, 0, 0);
        chk("over.turn_no", turn_no, 8'd3);
        chk("over.secs", 8'(secs_left), 8'd3);
        start_game = 1'b1;
        tick(1);
        chk_bits("over.start_blocked", 0, 0, 0, 0);
        game_over = 1'b0;
        tick(1);
        start_game = 1'b0;
        chk_bits("restart", 1, 0, 0, 0);
        chk("restart.turn_no", turn_no, 8'd0);
        chk("restart.secs", 8'(secs_left), 8'd3);

        // Reach FLIGHT, then async reset mid-cycle
        dog_throw = 1'b1;
        tick(1);
        dog_throw = 1'b0;
        tick(3);
        chk_bits("pre_rst.flight", 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bits("async_rst", 0, 0, 0, 0);
        chk("async_rst.secs", 8'(secs_left), 8'd0);
        #2;
        rst_n = 1'b1;
        tick(2);
        chk_bits("rst_idle", 0, 0, 0, 0);

        // Throw already high on AIM entry is not an edge: dropping it must not start a flight
        dog_throw = 1'b1;
        tick(1);
        start_game = 1'b1;
        tick(1);
        start_game = 1'b0;
        tick(2);
        dog_throw = 1'b0;
        tick(1);
        chk_bits("held_throw", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
